// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC calendar: bus layout, alarm mask bits, BCD months.
// Pure declarations; no latency or flow-control behaviour of its own.
package rtc_pkg;

  localparam int DAY_LSB  = 0;
  localparam int DAY_W    = 6;
  localparam int MON_LSB  = 8;
  localparam int MON_W    = 5;
  localparam int WDAY_LSB = 13;
  localparam int WDAY_W   = 3;
  localparam int YEAR_LSB = 16;

  localparam int MSK_DAY  = 0;
  localparam int MSK_MON  = 1;
  localparam int MSK_YEAR = 2;
  localparam int MSK_WDAY = 3;

  localparam logic [4:0] JAN = 5'h01;
  localparam logic [4:0] FEB = 5'h02;
  localparam logic [4:0] MAR = 5'h03;
  localparam logic [4:0] APR = 5'h04;
  localparam logic [4:0] MAY = 5'h05;
  localparam logic [4:0] JUN = 5'h06;
  localparam logic [4:0] JUL = 5'h07;
  localparam logic [4:0] AUG = 5'h08;
  localparam logic [4:0] SEP = 5'h09;
  localparam logic [4:0] OCT = 5'h10;
  localparam logic [4:0] NOV = 5'h11;
  localparam logic [4:0] DEC = 5'h12;

  // Returns {carry_out, digit}; a nibble above 9 still counts up modulo 16.
  function automatic logic [4:0] bcd_inc(input logic [3:0] d, input logic ci);
    if (!ci)
      bcd_inc = {1'b0, d};
    else if (d == 4'd9)
      bcd_inc = 5'b1_0000;
    else
      bcd_inc = {1'b0, d + 4'd1};
  endfunction

endpackage

// File: rtl/rtc_month_len.sv
// Last day of a BCD month for a BCD year, plus a legal-month flag.
// Combinational, no backpressure.
module rtc_month_len
  import rtc_pkg::*;
#(
  parameter int YEAR_DIGITS = 4,
  parameter int LEAP_MODE   = 0,
  localparam int YW         = 4 * YEAR_DIGITS
) (
  input  logic [4:0]    month,
  input  logic [YW-1:0] year,
  output logic [5:0]    last_day,
  output logic          mon_ok
);

  logic [15:0] y16;
  logic        leap;
  logic        unused_hi;

  assign y16       = 16'(year);
  assign unused_hi = ^y16[15:8];

  // Divisibility by 4 of the two-digit BCD number {t,u}.
  function automatic logic div4(input logic [3:0] t, input logic [3:0] u);
    div4 = t[0] ? (u == 4'd2 || u == 4'd6) : (u == 4'd0 || u == 4'd4 || u == 4'd8);
  endfunction

  always_comb begin
    leap = div4(y16[7:4], y16[3:0]);
    if (LEAP_MODE == 0 && YEAR_DIGITS == 4 && y16[7:0] == 8'h00)
      leap = div4(y16[15:12], y16[11:8]);
  end

  always_comb begin
    mon_ok   = 1'b1;
    last_day = 6'h00;
    case (month)
      JAN, MAR, MAY, JUL, AUG, OCT, DEC: last_day = 6'h31;
      APR, JUN, SEP, NOV:                last_day = 6'h30;
      FEB:                               last_day = leap ? 6'h29 : 6'h28;
      default:                           mon_ok   = 1'b0;
    endcase
  end

endmodule

// File: rtl/rtc_calendar.sv
// BCD calendar: advances one day per new_day_i, validates bus writes, raises carry and alarm pulses.
// All outputs registered, one cycle after the strobe; no backpressure, a write beats an advance.
module rtc_calendar
  import rtc_pkg::*;
#(
  parameter int          YEAR_DIGITS = 4,
  parameter int          LEAP_MODE   = 0,
  parameter logic [31:0] RST_DATE    = 32'h2000_0101,
  parameter int          ALARM_EN    = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        new_day_i,
  input  logic        date_we_i,
  input  logic [31:0] date_i,
  output logic [31:0] date_o,
  output logic        date_err_o,
  output logic        new_month_o,
  output logic        new_year_o,
  input  logic        alarm_we_i,
  input  logic [31:0] alarm_i,
  input  logic [3:0]  alarm_mask_i,
  input  logic        alarm_clr_i,
  output logic        alarm_o,
  output logic        alarm_pend_o
);

  localparam int YW = 4 * YEAR_DIGITS;

  logic [5:0]    day_q, day_nx, day_inc, last_cur, last_wr;
  logic [4:0]    mon_q, mon_nx, mon_inc;
  logic [2:0]    wday_q, wday_nx;
  logic [YW-1:0] year_q, year_nx;
  logic          ok_cur, ok_wr, mend, yend, adv, wr_ok;
  logic          date_err_q, new_month_q, new_year_q;
  logic [5:0]    wr_day;
  logic [4:0]    wr_mon;
  logic [2:0]    wr_wday;
  logic [YW-1:0] wr_year;
  logic          unused_in;

  assign unused_in = ^{date_i, alarm_i, alarm_mask_i, alarm_we_i, alarm_clr_i};

  assign wr_day  = date_i[DAY_LSB +: DAY_W];
  assign wr_mon  = date_i[MON_LSB +: MON_W];
  assign wr_wday = date_i[WDAY_LSB +: WDAY_W];
  assign wr_year = date_i[YEAR_LSB +: YW];

  rtc_month_len #(.YEAR_DIGITS(YEAR_DIGITS), .LEAP_MODE(LEAP_MODE)) u_len_cur (
    .month(mon_q), .year(year_q), .last_day(last_cur), .mon_ok(ok_cur)
  );

  rtc_month_len #(.YEAR_DIGITS(YEAR_DIGITS), .LEAP_MODE(LEAP_MODE)) u_len_wr (
    .month(wr_mon), .year(wr_year), .last_day(last_wr), .mon_ok(ok_wr)
  );

  assign adv  = new_day_i & ~date_we_i;
  assign mend = ok_cur && (day_q == last_cur);
  assign yend = mend && (mon_q == DEC);

  always_comb begin
    logic [4:0] t_lo, t_hi, ty;
    logic       c;
    t_lo    = bcd_inc(day_q[3:0], 1'b1);
    t_hi    = bcd_inc({2'b00, day_q[5:4]}, t_lo[4]);
    day_inc = {t_hi[1:0], t_lo[3:0]};
    t_lo    = bcd_inc(mon_q[3:0], 1'b1);
    mon_inc = {mon_q[4] ^ t_lo[4], t_lo[3:0]};
    day_nx  = mend ? 6'h01 : day_inc;
    mon_nx  = yend ? JAN : (mend ? mon_inc : mon_q);
    wday_nx = (wday_q == 3'd6) ? 3'd0 : wday_q + 3'd1;
    c       = yend;
    year_nx = year_q;
    for (int i = 0; i < YEAR_DIGITS; i++) begin
      ty                = bcd_inc(year_q[4*i +: 4], c);
      year_nx[4*i +: 4] = ty[3:0];
      c                 = ty[4];
    end
  end

  // BCD magnitude compare is valid once every nibble is known to be a digit.
  always_comb begin
    wr_ok = ok_wr && (wr_day[3:0] <= 4'd9) && (wr_day != 6'h00) &&
            (wr_day <= last_wr) && (wr_wday <= 3'd6);
    for (int i = 0; i < YEAR_DIGITS; i++)
      if (wr_year[4*i +: 4] > 4'd9) wr_ok = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      day_q       <= RST_DATE[DAY_LSB +: DAY_W];
      mon_q       <= RST_DATE[MON_LSB +: MON_W];
      wday_q      <= RST_DATE[WDAY_LSB +: WDAY_W];
      year_q      <= RST_DATE[YEAR_LSB +: YW];
      date_err_q  <= 1'b0;
      new_month_q <= 1'b0;
      new_year_q  <= 1'b0;
    end else begin
      date_err_q  <= 1'b0;
      new_month_q <= 1'b0;
      new_year_q  <= 1'b0;
      if (date_we_i) begin
        if (wr_ok) begin
          day_q  <= wr_day;
          mon_q  <= wr_mon;
          wday_q <= wr_wday;
          year_q <= wr_year;
        end else begin
          date_err_q <= 1'b1;
        end
      end else if (new_day_i) begin
        day_q       <= day_nx;
        mon_q       <= mon_nx;
        wday_q      <= wday_nx;
        year_q      <= year_nx;
        new_month_q <= mend;
        new_year_q  <= yend;
      end
    end
  end

  always_comb begin
    date_o                      = '0;
    date_o[DAY_LSB +: DAY_W]    = day_q;
    date_o[MON_LSB +: MON_W]    = mon_q;
    date_o[WDAY_LSB +: WDAY_W]  = wday_q;
    date_o[YEAR_LSB +: YW]      = year_q;
  end

  assign date_err_o  = date_err_q;
  assign new_month_o = new_month_q;
  assign new_year_o  = new_year_q;

  if (ALARM_EN != 0) begin : g_alarm
    logic [5:0]    al_day;
    logic [4:0]    al_mon;
    logic [2:0]    al_wday;
    logic [YW-1:0] al_year;
    logic [3:0]    al_mask;
    logic          hit, alarm_q, pend_q;

    // Compared against the value date_o is about to show, so the pulse lines up with it.
    assign hit = adv && (al_mask != 4'b0000) &&
                 (!al_mask[MSK_DAY]  || day_nx  == al_day)  &&
                 (!al_mask[MSK_MON]  || mon_nx  == al_mon)  &&
                 (!al_mask[MSK_YEAR] || year_nx == al_year) &&
                 (!al_mask[MSK_WDAY] || wday_nx == al_wday);

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        al_day  <= '0;
        al_mon  <= '0;
        al_wday <= '0;
        al_year <= '0;
        al_mask <= '0;
        alarm_q <= 1'b0;
        pend_q  <= 1'b0;
      end else begin
        if (alarm_we_i) begin
          al_day  <= alarm_i[DAY_LSB +: DAY_W];
          al_mon  <= alarm_i[MON_LSB +: MON_W];
          al_wday <= alarm_i[WDAY_LSB +: WDAY_W];
          al_year <= alarm_i[YEAR_LSB +: YW];
          al_mask <= alarm_mask_i;
        end
        alarm_q <= hit;
        pend_q  <= hit | (pend_q & ~alarm_clr_i);
      end
    end

    assign alarm_o      = alarm_q;
    assign alarm_pend_o = pend_q;
  end else begin : g_no_alarm
    assign alarm_o      = 1'b0;
    assign alarm_pend_o = 1'b0;
  end

endmodule

// File: tb/tb_rtc_calendar.sv
// Directed bench for rtc_calendar: default, divisible-by-4 leap and two-digit-year instances share stimulus.
module tb_rtc_calendar;

  logic        clk, rst;
  logic        new_day, date_we, alarm_we, alarm_clr;
  logic [31:0] date_in, alarm_in;
  logic [3:0]  alarm_mask;

  logic [31:0] d0_date, d1_date, d2_date;
  logic        d0_err, d1_err, d2_err;
  logic        d0_nm, d1_nm, d2_nm;
  logic        d0_ny, d1_ny, d2_ny;
  logic        d0_al, d1_al, d2_al;
  logic        d0_pd, d1_pd, d2_pd;

  int nchk = 0;
  int nerr = 0;

  rtc_calendar dut0 (
    .clk_i(clk), .rst_i(rst), .new_day_i(new_day), .date_we_i(date_we), .date_i(date_in),
    .date_o(d0_date), .date_err_o(d0_err), .new_month_o(d0_nm), .new_year_o(d0_ny),
    .alarm_we_i(alarm_we), .alarm_i(alarm_in), .alarm_mask_i(alarm_mask),
    .alarm_clr_i(alarm_clr), .alarm_o(d0_al), .alarm_pend_o(d0_pd)
  );

  rtc_calendar #(.LEAP_MODE(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .new_day_i(new_day), .date_we_i(date_we), .date_i(date_in),
    .date_o(d1_date), .date_err_o(d1_err), .new_month_o(d1_nm), .new_year_o(d1_ny),
    .alarm_we_i(alarm_we), .alarm_i(alarm_in), .alarm_mask_i(alarm_mask),
    .alarm_clr_i(alarm_clr), .alarm_o(d1_al), .alarm_pend_o(d1_pd)
  );

  rtc_calendar #(.YEAR_DIGITS(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .new_day_i(new_day), .date_we_i(date_we), .date_i(date_in),
    .date_o(d2_date), .date_err_o(d2_err), .new_month_o(d2_nm), .new_year_o(d2_ny),
    .alarm_we_i(alarm_we), .alarm_i(alarm_in), .alarm_mask_i(alarm_mask),
    .alarm_clr_i(alarm_clr), .alarm_o(d2_al), .alarm_pend_o(d2_pd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    new_day   = 1'b0;
    date_we   = 1'b0;
    alarm_we  = 1'b0;
    alarm_clr = 1'b0;
  endtask

  task automatic write_date(input logic [31:0] d);
    date_in = d;
    date_we = 1'b1;
    tick();
  endtask

  task automatic advance();
    new_day = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b1; new_day = 0; date_we = 0; alarm_we = 0; alarm_clr = 0;
    date_in = '0; alarm_in = '0; alarm_mask = '0;
    #2;
    chk("rst_date0", d0_date, 32'h2000_0101);
    chk("rst_date2", d2_date, 32'h0000_0101);
    chk("rst_pulses", {28'h0, d0_err, d0_nm, d0_ny, d0_al}, 32'h0);
    chk("rst_pend", {31'h0, d0_pd}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // January 2000 run-out: Feb 1 with weekday 3 after 31 days
    for (int i = 0; i < 31; i++) begin
      advance();
      chk("jan_newmonth", {31'h0, d0_nm}, {31'h0, (i == 30)});
    end
    chk("feb1_date0", d0_date, 32'h2000_6201);
    chk("feb1_date2", d2_date, 32'h0000_6201);

    write_date(32'h2000_0228);
    chk("wr_0228", d0_date, 32'h2000_0228);
    chk("wr_noerr", {31'h0, d0_err}, 32'h0);
    advance();
    chk("leap_0229", d0_date, 32'h2000_2229);
    chk("leap_nm0", {31'h0, d0_nm}, 32'h0);
    advance();
    chk("leap_0301", d0_date, 32'h2000_4301);
    chk("leap_nm1", {31'h0, d0_nm}, 32'h1);

    write_date(32'h1900_0228);
    advance();
    chk("greg_1900", d0_date, 32'h1900_2301);
    chk("div4_1900", d1_date, 32'h1900_2229);
    chk("y2_1900", d2_date, 32'h0000_2229);

    write_date(32'h9999_D231);
    chk("wr_9999", d0_date, 32'h9999_D231);
    chk("wr_y2_99", d2_date, 32'h0099_D231);
    chk("wr_no_carry", {30'h0, d0_nm, d0_ny}, 32'h0);
    advance();
    chk("wrap_date0", d0_date, 32'h0000_0101);
    chk("wrap_carry0", {30'h0, d0_nm, d0_ny}, 32'h3);
    chk("wrap_date2", d2_date, 32'h0000_0101);
    chk("wrap_ny2", {31'h0, d2_ny}, 32'h1);

    write_date(32'h2000_0431);
    chk("apr31_err", {31'h0, d0_err}, 32'h1);
    chk("apr31_keep", d0_date, 32'h0000_0101);
    tick();
    chk("err_oneshot", {31'h0, d0_err}, 32'h0);
    write_date(32'h2000_0A01);
    chk("monA_err", {31'h0, d0_err}, 32'h1);
    chk("monA_keep", d0_date, 32'h0000_0101);
    write_date(32'h2000_E101);
    chk("wday7_err", {31'h0, d0_err}, 32'h1);

    date_in = 32'h2000_0131; date_we = 1'b1; new_day = 1'b1; tick();
    chk("we_wins", d0_date, 32'h2000_0131);
    chk("we_wins_nm", {31'h0, d0_nm}, 32'h0);
    date_in = 32'h2000_0230; date_we = 1'b1; new_day = 1'b1; tick();
    chk("bad_we_wins", d0_date, 32'h2000_0131);
    chk("bad_we_err", {31'h0, d0_err}, 32'h1);

    // Alarm on January 5 by day+month
    write_date(32'h2000_0101);
    alarm_in = 32'h2000_0105; alarm_mask = 4'b0011; alarm_we = 1'b1; tick();
    for (int i = 0; i < 4; i++) begin
      advance();
      chk("alarm_seq", {31'h0, d0_al}, {31'h0, (i == 3)});
    end
    chk("alarm_pend", {31'h0, d0_pd}, 32'h1);
    advance();
    chk("alarm_after", {31'h0, d0_al}, 32'h0);
    chk("pend_sticky", {31'h0, d0_pd}, 32'h1);
    alarm_clr = 1'b1; tick();
    chk("pend_clr", {31'h0, d0_pd}, 32'h0);
    write_date(32'h2000_0105);
    chk("wr_no_alarm", {31'h0, d0_al}, 32'h0);
    write_date(32'h2000_0104);
    new_day = 1'b1; alarm_clr = 1'b1; tick();
    chk("set_beats_clr_al", {31'h0, d0_al}, 32'h1);
    chk("set_beats_clr_pd", {31'h0, d0_pd}, 32'h1);

    alarm_mask = 4'b0000; alarm_we = 1'b1; tick();
    write_date(32'h2000_0104);
    advance();
    chk("mask0_silent", {31'h0, d0_al}, 32'h0);

    // Asynchronous reset between edges
    advance();
    #2 rst = 1'b1;
    #1;
    chk("arst_date", d0_date, 32'h2000_0101);
    chk("arst_pend", {31'h0, d0_pd}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    advance();
    chk("post_rst_adv", d0_date, 32'h2000_2102);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
